// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, FSM state type and funct3 legality helper for the data-memory responder
package dmem_pkg;
    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_WAIT_CYCLES = 1;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        return we ? f3 inside {F3_B, F3_H, F3_W} : f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response bus between an initiator (master) and the data-memory responder (slave)
// req_*: valid/ready request with we, byte addr, right-aligned wdata, RV32I funct3
// rsp_*: valid/ready response with extended rdata and error flag
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    modport master (output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: store byte-enable/lane shift and load extract/extend for one 32-bit word
// addr_lo/funct3: access offset and size code; wdata: right-aligned store data; word: current memory word
// misalign: access violates natural alignment (only with DMEM_MISALIGN_ERR_EN); be/wdata_sh: store lanes; rdata: extended load data
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    input  logic [31:0] word,
    output logic        misalign,
    output logic [3:0]  be,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata
);
    logic [1:0]  off;
    logic [31:0] sh;
    always_comb begin
        // Halfword/word offsets are aligned down; when misalignment is an error the access is squashed anyway.
        off = funct3[1:0] == 2'b00 ? addr_lo : funct3[1:0] == 2'b01 ? {addr_lo[1], 1'b0} : 2'b00;
`ifdef DMEM_MISALIGN_ERR_EN
        misalign = (funct3[1:0] == 2'b01 && addr_lo[0]) || (funct3[1:0] == 2'b10 && addr_lo != 2'b00);
`else
        misalign = 1'b0;
`endif
        be = funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
        wdata_sh = wdata << {off, 3'b000};
        sh = word >> {off, 3'b000};
        rdata = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]} :
                funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
                funct3 == F3_BU ? {24'b0, sh[7:0]} :
                funct3 == F3_HU ? {16'b0, sh[15:0]} : word;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory responder with configurable response latency
// clk/rst: rising-edge clock, synchronous active-high reset (memory contents are kept)
// bus: dmem_if slave port; misalignment becomes an error when DMEM_MISALIGN_ERR_EN is defined
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
    input logic   clk,
    input logic   rst,
    dmem_if.slave bus
);
    localparam int IW = $clog2(DEPTH_WORDS);
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic        lat_we, a_we, accept, go_resp, misalign, err_c, err;
    logic [31:0] lat_addr, lat_wdata, a_addr, a_wdata, word, wdata_sh, ld_data, rdata;
    logic [2:0]  lat_f3, a_f3;
    logic [3:0]  be;
    logic [31:0] mem [DEPTH_WORDS];

    assign accept        = state == IDLE && bus.req_valid;
    assign bus.req_ready = state == IDLE;
    assign bus.rsp_valid = state == RESP;
    assign bus.rsp_rdata = rdata;
    assign bus.rsp_err   = err;
    // With zero wait cycles the access happens on the accept edge, so the live request is used instead of the latch.
    assign a_we    = state == IDLE ? bus.req_we     : lat_we;
    assign a_addr  = state == IDLE ? bus.req_addr   : lat_addr;
    assign a_wdata = state == IDLE ? bus.req_wdata  : lat_wdata;
    assign a_f3    = state == IDLE ? bus.req_funct3 : lat_f3;
    assign word    = mem[a_addr[IW+1:2]];
    assign err_c   = a_addr[31:2] >= 30'(DEPTH_WORDS) || !f3_legal(a_we, a_f3) || misalign;
    assign go_resp = state_n == RESP && state != RESP;

    dmem_lane_align u_align (
        .addr_lo  (a_addr[1:0]),
        .funct3   (a_f3),
        .wdata    (a_wdata),
        .word     (word),
        .misalign (misalign),
        .be       (be),
        .wdata_sh (wdata_sh),
        .rdata    (ld_data)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (accept) begin
            state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
            cnt_n   = WAIT_CYCLES == 0 ? 4'd0 : 4'(WAIT_CYCLES - 1);
        end else if (state == WAIT) begin
            state_n = cnt == 4'd0 ? RESP : WAIT;
            cnt_n   = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
        end else if (state == RESP && bus.rsp_ready) begin
            state_n = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
            err   <= 1'b0;
            rdata <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_we    <= bus.req_we;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_f3    <= bus.req_funct3;
            end
            if (go_resp) begin
                err   <= err_c;
                rdata <= err_c || a_we ? 32'd0 : ld_data;
            end
        end
    end

    // A reset on the commit edge squashes the store, so an aborted access never reaches memory.
    always_ff @(posedge clk) begin
        if (!rst && go_resp && a_we && !err_c)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[a_addr[IW+1:2]][8*i +: 8] <= wdata_sh[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table, hold/reset sequences and randomized checks against a byte-level model
module tb_dmem_responder;
    import dmem_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_if b1 ();
    dmem_if b3 ();
    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    dmem_responder #(.DEPTH_WORDS(16),   .WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(b3));

    int checks = 0;
    int failures = 0;
    logic [7:0] mb [int];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;
    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic acc1(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = we; b1.req_addr = addr; b1.req_wdata = wdata; b1.req_funct3 = f3;
        b1.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b1.req_valid = 1'b0;
        lat = 0; rd = 'x; er = 1'bx;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (b1.rsp_valid) begin lat = i; rd = b1.rsp_rdata; er = b1.rsp_err; end
        end
        if (lat == 0) begin checks++; failures++; $display("FAIL dut1_timeout: got no response expected rsp_valid"); end
        @(posedge clk);
    endtask

    task automatic acc3(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                        output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = we; b3.req_addr = addr; b3.req_wdata = wdata; b3.req_funct3 = f3;
        b3.rsp_ready = 1'b1;
        @(posedge clk);
        #1 b3.req_valid = 1'b0;
        lat = 0; rd = 'x; er = 1'bx;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            @(negedge clk);
            if (b3.rsp_valid) begin lat = i; rd = b3.rsp_rdata; er = b3.rsp_err; end
        end
        if (lat == 0) begin checks++; failures++; $display("FAIL dut3_timeout: got no response expected rsp_valid"); end
        @(posedge clk);
    endtask

    // Byte-addressed reference: size from funct3, little-endian assembly, then sign extension.
    function automatic void ref_acc(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [2:0] f3, output logic [31:0] rd, output logic er);
        int sz = f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
        int a = int'(addr);
        logic [31:0] v = 32'd0;
        rd = 32'd0;
        er = (addr >> 2) >= 32'd1024 || f3 == 3'd3 || f3 >= 3'd6 || (we && f3 >= 3'd4);
`ifdef DMEM_MISALIGN_ERR_EN
        if (int'(addr) % sz != 0) er = 1'b1;
`else
        a = int'(addr) - int'(addr) % sz;
`endif
        if (er) return;
        for (int i = 0; i < sz; i++)
            if (we) mb[a + i] = wdata[8*i +: 8];
            else v = v | (32'(mb[a + i]) << (8 * i));
        if (!we) rd = (!f3[2] && sz < 4 && v[8*sz-1]) ? v | (32'hFFFF_FFFF << (8 * sz)) : v;
    endfunction

    initial begin
        logic [31:0] rd, mrd, a;
        logic er, mer, we;
        logic [2:0] f3;
        int lat, bad;
        tbl[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 3'd2, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 32'h10,   32'h0,        3'd2, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h20,   32'h11223344, 3'd2, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 32'h21,   32'hAA,       3'd0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 32'h20,   32'h0,        3'd2, 32'h1122AA44, 1'b0};
        tbl[5]  = '{1'b0, 32'h21,   32'h0,        3'd0, 32'hFFFFFFAA, 1'b0};
        tbl[6]  = '{1'b0, 32'h21,   32'h0,        3'd4, 32'h000000AA, 1'b0};
        tbl[7]  = '{1'b1, 32'h0,    32'hCAFEF00D, 3'd2, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 32'h1000, 32'h0,        3'd2, 32'h0,        1'b1};
        tbl[9]  = '{1'b1, 32'h1000, 32'h12345678, 3'd2, 32'h0,        1'b1};
        tbl[10] = '{1'b0, 32'h0,    32'h0,        3'd2, 32'hCAFEF00D, 1'b0};
        tbl[11] = '{1'b1, 32'h20,   32'h80017F00, 3'd2, 32'h0,        1'b0};
        tbl[12] = '{1'b0, 32'h22,   32'h0,        3'd1, 32'hFFFF8001, 1'b0};
`ifdef DMEM_MISALIGN_ERR_EN
        tbl[13] = '{1'b0, 32'h23,   32'h0,        3'd1, 32'h0,        1'b1};
`else
        tbl[13] = '{1'b0, 32'h23,   32'h0,        3'd1, 32'hFFFF8001, 1'b0};
`endif
        tbl[14] = '{1'b0, 32'h22,   32'h0,        3'd5, 32'h00008001, 1'b0};
        tbl[15] = '{1'b0, 32'h20,   32'h0,        3'd3, 32'h0,        1'b1};
        tbl[16] = '{1'b1, 32'h20,   32'h0,        3'd4, 32'h0,        1'b1};
        tbl[17] = '{1'b0, 32'h20,   32'h0,        3'd2, 32'h80017F00, 1'b0};
        tbl[18] = '{1'b1, 32'h22,   32'h1234BEEF, 3'd1, 32'h0,        1'b0};
        tbl[19] = '{1'b0, 32'h20,   32'h0,        3'd2, 32'hBEEF7F00, 1'b0};

        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_funct3 = '0; b1.rsp_ready = 1'b1;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = '0; b3.req_wdata = '0; b3.req_funct3 = '0; b3.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_req_ready", 32'(b1.req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("reset_rsp_rdata", b1.rsp_rdata, 32'd0);
        chk("reset_rsp_err",   32'(b1.rsp_err), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            acc1(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].f3, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), 32'(er), 32'(tbl[i].exp_er));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
        end

        @(negedge clk);
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 32'h10; b1.req_funct3 = 3'd2; b1.rsp_ready = 1'b0;
        @(posedge clk);
        #1 b1.req_valid = 1'b0;
        for (int i = 0; i < 20 && !b1.rsp_valid; i++) @(negedge clk);
        chk("hold_rsp_valid", 32'(b1.rsp_valid), 32'd1);
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_wdata = 32'h0;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (!(b1.rsp_valid && b1.rsp_rdata == 32'hDEADBEEF && !b1.req_ready)) bad++;
        end
        chk("hold_stable_cycles_bad", 32'(bad), 32'd0);
        b1.req_valid = 1'b0; b1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_exit_rsp_valid", 32'(b1.rsp_valid), 32'd0);
        chk("hold_exit_req_ready", 32'(b1.req_ready), 32'd1);
        acc1(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
        chk("hold_ignored_store", rd, 32'hDEADBEEF);

        for (int w = 0; w < 16; w++) begin
            a = 32'h100 + 32'(4 * w);
            we = 1'b1; f3 = 3'd2; mrd = $urandom;
            ref_acc(we, a, mrd, f3, rd, mer);
            acc1(we, a, mrd, f3, rd, er, lat);
            chk("rand_init_err", 32'(er), 32'd0);
        end
        for (int n = 0; n < 150; n++) begin
            logic [31:0] wd;
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            a  = $urandom_range(0, 7) == 0 ? (32'h1000 | $urandom) : 32'h100 + 32'($urandom_range(0, 63));
            ref_acc(we, a, wd, f3, mrd, mer);
            acc1(we, a, wd, f3, rd, er, lat);
            chk($sformatf("rand%0d_rdata we=%0d f3=%0d a=%08h", n, we, f3, a), rd, mrd);
            chk($sformatf("rand%0d_err", n), 32'(er), 32'(mer));
            chk($sformatf("rand%0d_latency", n), 32'(lat), 32'd2);
        end

        acc3(1'b1, 32'h0, 32'hA5A5A5A5, 3'd2, rd, er, lat);
        chk("w3_store_latency", 32'(lat), 32'd4);
        @(negedge clk);
        b3.req_valid = 1'b1; b3.req_we = 1'b1; b3.req_addr = 32'h0; b3.req_wdata = 32'h5; b3.req_funct3 = 3'd2;
        @(posedge clk);
        #1 b3.req_valid = 1'b0;
        @(negedge clk);
        chk("w3_wait_req_ready", 32'(b3.req_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("w3_reset_rsp_valid", 32'(b3.rsp_valid), 32'd0);
        chk("w3_reset_rsp_err",   32'(b3.rsp_err), 32'd0);
        chk("w3_reset_rsp_rdata", b3.rsp_rdata, 32'd0);
        chk("w3_reset_req_ready", 32'(b3.req_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("w3_post_reset_req_ready", 32'(b3.req_ready), 32'd1);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (b3.rsp_valid) bad++;
        end
        chk("w3_no_late_response", 32'(bad), 32'd0);
        acc3(1'b0, 32'h0, 32'h0, 3'd2, rd, er, lat);
        chk("w3_word0_kept", rd, 32'hA5A5A5A5);
        chk("w3_load_latency", 32'(lat), 32'd4);
        acc1(1'b0, 32'h10, 32'h0, 3'd2, rd, er, lat);
        chk("mem_survives_reset", rd, 32'hDEADBEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit storage words (power of two, at least 4).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, meaning the extra cycles between request accept and response, with a legal range of 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have these request-side ports:
- req_valid, input, 1 bit: the initiator presents an access.
- req_ready, output, 1 bit: the responder can accept.
- req_we, input, 1 bit: 1 means store, 0 means load.
- req_addr, input, 32 bits: the byte address.
- req_wdata, input, 32 bits: store data, right-aligned.
- req_funct3, input, 3 bits: the RV32I size/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-006 The block SHALL have these response-side ports:
- rsp_valid, output, 1 bit: a response is present.
- rsp_ready, input, 1 bit: the initiator takes the response.
- rsp_rdata, output, 32 bits: load data, extended per funct3.
- rsp_err, output, 1 bit: the access faulted.

Function
REQ-007 The FSM SHALL have exactly the states IDLE, WAIT and RESP.
REQ-008 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-009 A request SHALL be accepted on a rising edge when req_valid=1 and req_ready=1, and it SHALL latch req_we, req_addr, req_wdata and req_funct3.
REQ-010 After accept, the FSM SHALL go to WAIT with its counter loaded to WAIT_CYCLES-1 if WAIT_CYCLES>0; otherwise it SHALL go directly to RESP.
REQ-011 WAIT SHALL decrement the counter each cycle and SHALL go to RESP on the edge where the counter equals 0.
REQ-012 The memory access (store commit or load capture) SHALL occur on the edge that enters RESP, so that accept-to-rsp_valid latency is WAIT_CYCLES+1 cycles.
REQ-013 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL be held stable until an edge with rsp_ready=1, after which the FSM SHALL return to IDLE.
REQ-014 New requests SHALL NOT be accepted in the RESP exit cycle, so that back-to-back throughput is one access per WAIT_CYCLES+2 cycles.
REQ-015 Loads SHALL follow these rules:
- B/H select the byte at addr[1:0] or the halfword at addr[1]*2.
- B/H are sign-extended; BU/HU are zero-extended.
- W returns the whole word.
REQ-016 Stores SHALL write only the addressed lanes (SB: 1 byte, SH: 2 bytes, SW: 4 bytes), and all other bytes of the word SHALL be unchanged.
REQ-017 The word index SHALL be addr[31:2], and an index of DEPTH_WORDS or above SHALL give rsp_err=1 and rsp_rdata=0, with no write.
REQ-018 Illegal funct3 values (011, 110, 111, and 1xx on a store) SHALL give rsp_err=1 and rsp_rdata=0, with no write.
REQ-019 On a store response, rsp_rdata SHALL be 0.
REQ-020 Requests presented while req_ready=0 SHALL be ignored, with no queuing.

Reset
REQ-021 While rst=1 at a rising edge, the block SHALL set: state IDLE, counter 0, rsp_valid 0, rsp_err 0, rsp_rdata 0, req_ready 1 on the following cycle.
REQ-022 A reset during WAIT SHALL abort the access, and a store not yet committed SHALL NOT modify memory.
REQ-023 Reset SHALL NOT clear memory contents.

Configuration
REQ-024 With macro DMEM_MISALIGN_ERR_EN defined, a halfword access with addr[0]=1 or a word access with addr[1:0]!=0 SHALL complete with rsp_err=1, rsp_rdata=0, and no write.
REQ-025 Without DMEM_MISALIGN_ERR_EN, the offending low address bits SHALL be forced to 0 (the access aligns down) and rsp_err SHALL NOT be raised for misalignment.

Structure
REQ-026 Package dmem_pkg SHALL hold the funct3 size constants, the FSM state enum, and the default DEPTH_WORDS/WAIT_CYCLES constants.
REQ-027 Sub-module dmem_lane_align SHALL hold the combinational store byte-enable/lane-shift logic and the load extract/extend logic; the FSM, counter and storage array SHALL stay in dmem_responder.

Verification
REQ-028 The bench SHALL cover at least the following directed scenarios:
- WAIT_CYCLES=1: SW 0xDEADBEEF to 0x10, then LW 0x10 -> rsp_rdata=0xDEADBEEF, rsp_valid rising 2 cycles after each accept, rsp_err=0.
- Word at 0x20 preset to 0x11223344: SB 0xAA to 0x21, then LW 0x20 -> 0x1122AA44; LB 0x21 -> 0xFFFFFFAA; LBU 0x21 -> 0x000000AA.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable, req_ready=0, a second req_valid ignored; rsp_ready=1 -> IDLE next cycle.
- DEPTH_WORDS=1024: LW 0x00001000 -> rsp_err=1, rsp_rdata=0; SW to 0x1000 followed by LW 0x0 shows word 0 unchanged.
- LH 0x22 with word 0x20 = 0x8001xxxx -> 0xFFFF8001; LH 0x23 -> rsp_err=1 with DMEM_MISALIGN_ERR_EN defined, or the same data as LH 0x22 without it.
- WAIT_CYCLES=3: assert rst during WAIT of an SW 0x5 to 0x0 -> outputs at reset values, word 0 keeps its old value, and req_ready=1 the cycle after reset deasserts.
